// File: rtl/gf2_div_pkg.sv
//------------------------------------------------------------------------------
// gf2_div_pkg : widths, state encoding and reference model for the GF(2) divider
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gf2_div_pkg;

   localparam int DIVIDEND_W = 31;
   localparam int DIVISOR_W  = 17;
   localparam int QUOT_W     = 15;
   localparam int REM_W      = 16;

   localparam logic [DIVISOR_W-1:0] GF16_DEFAULT_POLY = 17'h1002B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic              err;
      logic [QUOT_W-1:0] quot;
      logic [REM_W-1:0]  rem;
   } div_res_t;

   // Textbook long division over the whole dividend; bench-side reference only.
   function automatic div_res_t gf2_div_ref(input logic [DIVIDEND_W-1:0] dividend,
                                            input logic [DIVISOR_W-1:0]  divisor);
      logic [DIVIDEND_W-1:0] acc;
      div_res_t              res;
      res = '0;
      acc = dividend;
      if (!divisor[DIVISOR_W-1]) begin
         res.err = 1'b1;
         return res;
      end
      for (int i = DIVIDEND_W - 1; i >= REM_W; i--) begin
         if (acc[i]) begin
            acc = acc ^ (DIVIDEND_W'(divisor) << (i - REM_W));
            res.quot[i-REM_W] = 1'b1;
         end
      end
      res.rem = acc[REM_W-1:0];
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gf2_div_step.sv
//------------------------------------------------------------------------------
// gf2_div_step : one combinational step of GF(2) long division
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gf2_div_step
   import gf2_div_pkg::*;
(
   input  logic [REM_W-1:0] i_r,
   input  logic             i_din,
   input  logic [REM_W-1:0] i_poly,
   output logic [REM_W-1:0] o_r_next,
   output logic             o_qbit
);

   logic [REM_W:0] w_t;

   // The implicit x^16 term of the monic modulus cancels w_t[16], so only P is XORed.
   assign w_t      = {i_r, i_din};
   assign o_qbit   = w_t[REM_W];
   assign o_r_next = w_t[REM_W-1:0] ^ (w_t[REM_W] ? i_poly : '0);

endmodule

`default_nettype wire

// File: rtl/gf2_poly_div_16bit.sv
//------------------------------------------------------------------------------
// gf2_poly_div_16bit : sequential carry-less divider, 31-bit / monic degree-16
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gf2_poly_div_16bit
   import gf2_div_pkg::*;
#(
   parameter int ITER_PER_CYCLE = 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOT_W-1:0]     quotient,
   output logic [REM_W-1:0]      remainder,
   output logic                  err
);

   localparam logic [3:0] C_STEP = 4'(ITER_PER_CYCLE);
   localparam logic [3:0] C_LAST = 4'd15;

   generate
      if (!(ITER_PER_CYCLE == 1 || ITER_PER_CYCLE == 3 ||
            ITER_PER_CYCLE == 5 || ITER_PER_CYCLE == 15)) begin : g_bad_iter
         $error("gf2_poly_div_16bit: ITER_PER_CYCLE must be 1, 3, 5 or 15");
      end
   endgenerate

   state_t            r_state;
   logic [REM_W-1:0]  r_rem;
   logic [QUOT_W-1:0] r_dsh;
   logic [REM_W-1:0]  r_poly;
   logic [QUOT_W-1:0] r_quot;
   logic [3:0]        r_cnt;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_err;

   logic [REM_W-1:0]  w_r [ITER_PER_CYCLE+1];
   logic [QUOT_W-1:0] w_q [ITER_PER_CYCLE+1];
   logic [3:0]        w_cnt_next;

   assign w_r[0]     = r_rem;
   assign w_q[0]     = r_quot;
   assign w_cnt_next = r_cnt + C_STEP;

   // Dividend low bits are consumed MSB-first; step k of a cycle takes bit 14-k.
   generate
      for (genvar k = 0; k < ITER_PER_CYCLE; k++) begin : g_step
         logic w_qbit;
         gf2_div_step u_step (
            .i_r      (w_r[k]),
            .i_din    (r_dsh[QUOT_W-1-k]),
            .i_poly   (r_poly),
            .o_r_next (w_r[k+1]),
            .o_qbit   (w_qbit)
         );
         assign w_q[k+1] = {w_q[k][QUOT_W-2:0], w_qbit};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rem       <= '0;
         r_dsh       <= '0;
         r_poly      <= '0;
         r_quot      <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_quot     <= '0;
                  if (divisor[DIVISOR_W-1]) begin
                     r_rem   <= dividend[DIVIDEND_W-1:QUOT_W];
                     r_dsh   <= dividend[QUOT_W-1:0];
                     r_poly  <= divisor[REM_W-1:0];
                     r_cnt   <= '0;
                     r_err   <= 1'b0;
                     r_state <= RUN;
                  end else begin
                     r_rem       <= '0;
                     r_err       <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            RUN: begin
               r_rem  <= w_r[ITER_PER_CYCLE];
               r_quot <= w_q[ITER_PER_CYCLE];
               r_dsh  <= r_dsh << ITER_PER_CYCLE;
               r_cnt  <= w_cnt_next;
               if (w_cnt_next == C_LAST) begin
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign quotient  = r_quot;
   assign remainder = r_rem;
   assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_gf2_poly_div_16bit.sv
//------------------------------------------------------------------------------
// tb_gf2_poly_div_16bit : runs four divider instances (1/3/5/15 steps per clock)
// in lockstep against a queue of expected results.
//------------------------------------------------------------------------------
`default_nettype none

module tb_gf2_poly_div_16bit;
   import gf2_div_pkg::*;

   localparam int C_NDUT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [30:0] dividend = '0;
   logic [16:0] divisor = '0;

   logic        in_ready_a  [C_NDUT];
   logic        out_valid_a [C_NDUT];
   logic        err_a       [C_NDUT];
   logic [14:0] quot_a      [C_NDUT];
   logic [15:0] rem_a       [C_NDUT];

   int n_checks = 0;
   int n_errors = 0;
   div_res_t sb [$];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < C_NDUT; g++) begin : g_dut
         localparam int C_IT = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 15;
         gf2_poly_div_16bit #(.ITER_PER_CYCLE(C_IT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_a[g]),
            .dividend  (dividend),
            .divisor   (divisor),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready),
            .quotient  (quot_a[g]),
            .remainder (rem_a[g]),
            .err       (err_a[g])
         );
      end
   endgenerate

   function automatic int iter_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 5 : 15;
   endfunction

   function automatic logic [30:0] clmul(input logic [14:0] a, input logic [16:0] b);
      logic [30:0] acc;
      acc = '0;
      for (int i = 0; i < 15; i++)
         if (a[i]) acc = acc ^ (31'(b) << i);
      return acc;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Ends on the falling edge right after the acceptance edge; inputs are then scrambled.
   task automatic accept(input logic [30:0] dd, input logic [16:0] dv, input div_res_t e);
      @(negedge clk);
      for (int k = 0; k < C_NDUT; k++) chk($sformatf("in_ready_idle[%0d]", k), 32'(in_ready_a[k]), 1);
      in_valid = 1'b1;
      dividend = dd;
      divisor  = dv;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 31'($urandom);
      divisor  = 17'($urandom);
   endtask

   task automatic wait_results();
      int       seen [C_NDUT];
      bit       all_seen;
      div_res_t e;
      for (int k = 0; k < C_NDUT; k++) seen[k] = -1;
      for (int n = 0; n < 40; n++) begin
         all_seen = 1'b1;
         for (int k = 0; k < C_NDUT; k++) begin
            if (seen[k] < 0 && out_valid_a[k]) seen[k] = n;
            if (seen[k] < 0) all_seen = 1'b0;
         end
         if (all_seen) break;
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'(sb.size()), 1);
         return;
      end
      e = sb.pop_front();
      for (int k = 0; k < C_NDUT; k++) begin
         chk($sformatf("latency[%0d]", k), 32'(seen[k]), e.err ? 0 : 32'(15 / iter_of(k)));
         chk($sformatf("quotient[%0d]", k), 32'(quot_a[k]), 32'(e.quot));
         chk($sformatf("remainder[%0d]", k), 32'(rem_a[k]), 32'(e.rem));
         chk($sformatf("err[%0d]", k), 32'(err_a[k]), 32'(e.err));
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < C_NDUT; k++) begin
         chk($sformatf("out_valid_drop[%0d]", k), 32'(out_valid_a[k]), 0);
         chk($sformatf("in_ready_rise[%0d]", k), 32'(in_ready_a[k]), 1);
      end
   endtask

   task automatic run_op(input logic [30:0] dd, input logic [16:0] dv, input div_res_t e);
      accept(dd, dv, e);
      wait_results();
      release_out();
   endtask

   initial begin
      logic [14:0] q;
      logic [15:0] r;
      logic [16:0] dv;
      logic [30:0] dd;
      bit          pulsed;
      div_res_t    e;

      #1 rst = 1'b1;
      #1;
      for (int k = 0; k < C_NDUT; k++) begin
         chk($sformatf("rst_in_ready[%0d]", k), 32'(in_ready_a[k]), 1);
         chk($sformatf("rst_out_valid[%0d]", k), 32'(out_valid_a[k]), 0);
         chk($sformatf("rst_err[%0d]", k), 32'(err_a[k]), 0);
         chk($sformatf("rst_q[%0d]", k), 32'(quot_a[k]), 0);
         chk($sformatf("rst_r[%0d]", k), 32'(rem_a[k]), 0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_op(31'h0,     17'h1002B, '{err: 1'b0, quot: 15'h0, rem: 16'h0});
      run_op(31'h1002B, 17'h1002B, '{err: 1'b0, quot: 15'h1, rem: 16'h0});
      run_op(31'h12345, 17'h1002B, '{err: 1'b0, quot: 15'h1, rem: 16'h236E});
      run_op(31'h20057, 17'h1002B, '{err: 1'b0, quot: 15'h2, rem: 16'h1});
      run_op(31'h5A5A5A5A, 17'h0FFFF, '{err: 1'b1, quot: 15'h0, rem: 16'h0});

      // Backpressure: result held for 6 cycles while a competing operand is offered.
      accept(31'h12345, 17'h1002B, '{err: 1'b0, quot: 15'h1, rem: 16'h236E});
      wait_results();
      in_valid = 1'b1;
      dividend = 31'h20057;
      divisor  = 17'h1002B;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int k = 0; k < C_NDUT; k++) begin
            chk($sformatf("hold_out_valid[%0d]", k), 32'(out_valid_a[k]), 1);
            chk($sformatf("hold_in_ready[%0d]", k), 32'(in_ready_a[k]), 0);
            chk($sformatf("hold_q[%0d]", k), 32'(quot_a[k]), 32'h1);
            chk($sformatf("hold_r[%0d]", k), 32'(rem_a[k]), 32'h236E);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < C_NDUT; k++) begin
         chk($sformatf("bp_idle_in_ready[%0d]", k), 32'(in_ready_a[k]), 1);
         chk($sformatf("bp_idle_out_valid[%0d]", k), 32'(out_valid_a[k]), 0);
      end
      sb.push_back('{err: 1'b0, quot: 15'h2, rem: 16'h1});
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < C_NDUT; k++) chk($sformatf("bp_accepted[%0d]", k), 32'(in_ready_a[k]), 0);
      wait_results();
      release_out();

      // Reset in the middle of RUN (cnt=7 for the single-step instance).
      accept(31'h1234_5678, 17'h1002B, '{err: 1'b0, quot: 15'h0, rem: 16'h0});
      repeat (7) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      #1;
      for (int k = 0; k < C_NDUT; k++) begin
         chk($sformatf("midrst_in_ready[%0d]", k), 32'(in_ready_a[k]), 1);
         chk($sformatf("midrst_out_valid[%0d]", k), 32'(out_valid_a[k]), 0);
         chk($sformatf("midrst_q[%0d]", k), 32'(quot_a[k]), 0);
         chk($sformatf("midrst_r[%0d]", k), 32'(rem_a[k]), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      pulsed = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int k = 0; k < C_NDUT; k++) if (out_valid_a[k]) pulsed = 1'b1;
      end
      chk("no_output_after_reset", 32'(pulsed), 0);
      dd = 31'h7ABC_1234;
      run_op(dd, GF16_DEFAULT_POLY, gf2_div_ref(dd, GF16_DEFAULT_POLY));

      for (int i = 0; i < 1000; i++) begin
         if (i % 50 == 49) begin
            dv = 17'($urandom) & 17'h0FFFF;
            dd = 31'($urandom);
            run_op(dd, dv, '{err: 1'b1, quot: 15'h0, rem: 16'h0});
         end else begin
            dv = {1'b1, 16'($urandom)};
            q  = 15'($urandom);
            r  = 16'($urandom);
            dd = clmul(q, dv) ^ {15'b0, r};
            run_op(dd, dv, '{err: 1'b0, quot: q, rem: r});
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gf2_poly_div_16bit.md
Name: gf2_poly_div_16bit

Overview:
- Sequential GF(2) polynomial divider: inverse of the 16-bit Karatsuba carry-less multiplier datapath.
- Takes a 31-bit product polynomial and a monic degree-16 modulus.
- Returns a 15-bit quotient and a 16-bit remainder using bit-serial long division, ITER_PER_CYCLE steps per clock.
- Sits after the multiplier to reduce products into GF(2^16), and serves as a bench checker for multiplier outputs.

Parameters:
- ITER_PER_CYCLE, 1, division steps per clock. Legal values are 1, 3, 5, 15. Any other value is an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  31  polynomial; bit i = coefficient of x^i.
- divisor  input  17  modulus; bit 16 must be 1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  15  q(x).
- remainder  output  16  r(x), degree < 16.
- err  output  1  divisor[16] was 0; q and r are forced to 0.

Behaviour:
- Math: dividend = quotient*divisor XOR remainder, all carry-less. Every add is an XOR; no carries anywhere.
- States: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, in_ready=1, out_valid=0, err=0.
  - quotient=0, remainder=0, iteration counter=0.
  - The in-flight operation is discarded; no output is produced for it.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1 and divisor[16]=1:
    - R <= dividend[30:15].
    - D <= dividend[14:0] (shift register).
    - P <= divisor[15:0].
    - cnt <= 0; go to RUN.
  - On an edge with in_valid=1 and divisor[16]=0: err<=1, quotient<=0, remainder<=0; go to DONE. Latency is 1 edge.
- Division step (combinational):
  - t = {R, D[14]} (17 bits).
  - q bit = t[16].
  - R' = t[15:0] XOR (t[16] ? P : 0).
  - D' = D<<1.
  - The quotient register shifts left and takes the q bit in its LSB.
- RUN:
  - in_ready=0.
  - Each edge applies ITER_PER_CYCLE chained steps and advances cnt by ITER_PER_CYCLE.
  - After the edge where cnt reaches 15: quotient and remainder hold the final values, err=0, go to DONE.
  - Acceptance-to-out_valid latency = 15/ITER_PER_CYCLE edges (15, 5, 3 or 1).
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs hold stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: go to IDLE. out_valid drops and in_ready rises the following cycle; there is no same-cycle turnaround.
- Inputs are ignored outside IDLE. dividend and divisor are sampled only at acceptance and may change afterwards.
- Outputs keep their last values in IDLE; they are qualified only by out_valid.
- Throughput (ITER_PER_CYCLE=1): one result per 17 cycles minimum (1 accept + 15 RUN + 1 DONE handshake).

Decomposition:
- Package gf2_div_pkg holds:
  - Width constants: DIVIDEND_W=31, DIVISOR_W=17, QUOT_W=15, REM_W=16.
  - State enum: IDLE, RUN, DONE.
  - Constant GF16_DEFAULT_POLY = 17'h1002B (x^16+x^5+x^3+x+1).
  - Function gf2_div_ref, used only by the bench model.
- Sub-module gf2_div_step: combinational single step.
  - Inputs: R[15:0], din bit, P[15:0].
  - Outputs: R_next[15:0], qbit.
  - Instantiated ITER_PER_CYCLE times in a chain.

Test Plan:
- Zero dividend: dividend=0, divisor=0x1002B -> after 15 edges (ITER_PER_CYCLE=1), out_valid=1, quotient=0x0000, remainder=0x0000, err=0.
- Exact division: dividend=0x1002B, divisor=0x1002B -> quotient=0x0001, remainder=0x0000.
- Remainder nonzero:
  - dividend=0x12345, divisor=0x1002B -> quotient=0x0001, remainder=0x236E.
  - dividend=0x20057 -> quotient=0x0002, remainder=0x0001.
- Illegal divisor: divisor=0x0FFFF with any dividend -> out_valid=1 one edge after acceptance, err=1, quotient=0, remainder=0.
- Backpressure and ordering:
  - Hold out_ready=0 for 6 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is not accepted.
  - Release out_ready -> the next operand is accepted only after the return to IDLE.
- Reset and randomized check:
  - Assert rst for 1 cycle at RUN cnt=7 -> IDLE immediately, out_valid never pulses for that operation, and the next operation completes correctly.
  - Repeat with ITER_PER_CYCLE of 1, 3, 5 and 15 using 1000 random (q, r) pairs, where dividend = q*P XOR r, checking latency of 15, 5, 3 and 1 edges respectively.
